// File: rtl/mem_wb_elastic_if.sv
// MEM/WB stage bus: upstream handshake and entry fields, downstream handshake
// and held fields, plus the forwarding tap toward the hazard unit.
interface mem_wb_elastic_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_mem;
    logic [REG_AW-1:0] in_wn;

    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_mem;
    logic [REG_AW-1:0] out_wn;

    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_wn;
    logic [DATA_W-1:0] fwd_data;

    // Master is the side that feeds MEM entries in and consumes them at WB.
    modport master (
        output in_valid, in_ctrl, in_alu, in_mem, in_wn, out_ready,
        input  in_ready, out_valid, out_ctrl, out_alu, out_mem, out_wn,
        input  fwd_valid, fwd_wn, fwd_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_alu, in_mem, in_wn, out_ready,
        output in_ready, out_valid, out_ctrl, out_alu, out_mem, out_wn,
        output fwd_valid, fwd_wn, fwd_data
    );
endinterface

// File: rtl/mem_wb_elastic.sv
// Elastic MEM/WB stage: main register plus one skid entry, registered in_ready,
// synchronous flush. Define MEM_WB_FWD_EN to drive the forwarding tap.
module mem_wb_elastic #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    mem_wb_elastic_if.slave      bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              inReady_q, inReady_d;
    logic [CTRL_W-1:0] mainCtrl_q, skidCtrl_q;
    logic [DATA_W-1:0] mainAlu_q, skidAlu_q;
    logic [DATA_W-1:0] mainMem_q, skidMem_q;
    logic [REG_AW-1:0] mainWn_q, skidWn_q;

    logic              outValid;
    logic [CTRL_W-1:0] outCtrl;
    logic              accept, drain;
    logic              loadMainIn, loadMainSkid, loadSkid;

    assign outValid = (state_q != EMPTY);
    assign outCtrl  = outValid ? mainCtrl_q : '0;
    assign accept   = bus.in_valid & inReady_q;
    assign drain    = outValid & bus.out_ready;

    always_comb begin
        state_d      = state_q;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        loadMainIn = 1'b1;
                        state_d    = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        loadMainIn = 1'b1;
                    end else if (accept) begin
                        loadSkid = 1'b1;
                        state_d  = FULL;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        loadMainSkid = 1'b1;
                        state_d      = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Ready is a pure function of the next occupancy, so it leaves the flop directly.
    assign inReady_d = (state_d != FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            inReady_q  <= 1'b1;
            mainCtrl_q <= '0;
            mainAlu_q  <= '0;
            mainMem_q  <= '0;
            mainWn_q   <= '0;
            skidCtrl_q <= '0;
            skidAlu_q  <= '0;
            skidMem_q  <= '0;
            skidWn_q   <= '0;
        end else begin
            state_q   <= state_d;
            inReady_q <= inReady_d;
            if (loadMainIn) begin
                mainCtrl_q <= bus.in_ctrl;
                mainAlu_q  <= bus.in_alu;
                mainMem_q  <= bus.in_mem;
                mainWn_q   <= bus.in_wn;
            end else if (loadMainSkid) begin
                mainCtrl_q <= skidCtrl_q;
                mainAlu_q  <= skidAlu_q;
                mainMem_q  <= skidMem_q;
                mainWn_q   <= skidWn_q;
            end
            if (loadSkid) begin
                skidCtrl_q <= bus.in_ctrl;
                skidAlu_q  <= bus.in_alu;
                skidMem_q  <= bus.in_mem;
                skidWn_q   <= bus.in_wn;
            end
        end
    end

    assign bus.in_ready  = inReady_q;
    assign bus.out_valid = outValid;
    assign bus.out_ctrl  = outCtrl;
    assign bus.out_alu   = mainAlu_q;
    assign bus.out_mem   = mainMem_q;
    assign bus.out_wn    = mainWn_q;

`ifdef MEM_WB_FWD_EN
    assign bus.fwd_valid = outValid & outCtrl[0];
    assign bus.fwd_wn    = mainWn_q;
    assign bus.fwd_data  = outCtrl[1] ? mainMem_q : mainAlu_q;
`else
    assign bus.fwd_valid = 1'b0;
    assign bus.fwd_wn    = '0;
    assign bus.fwd_data  = '0;
`endif
endmodule
